// File: rtl/stage_mem_lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_defs : memory-op encoding and op-class helpers for the MEM stage
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_defs;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_LWU  = 4'd6,
    MEM_LD   = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10,
    MEM_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  function automatic logic is_load(mem_op_e op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_LWU, MEM_LD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(mem_op_e op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW, MEM_SD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic mem_size_e op_size(mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB:          return SZ_B;
      MEM_LH, MEM_LHU, MEM_SH:          return SZ_H;
      MEM_LW, MEM_LWU, MEM_SW:          return SZ_W;
      default:                          return SZ_D;
    endcase
  endfunction

  function automatic logic is_signed(mem_op_e op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // LWU/LD/SD only exist on RV64; on RV32 they behave as non-memory ops
  function automatic logic op_legal(mem_op_e op, int xlen);
    if (!(is_load(op) || is_store(op))) return 1'b0;
    if (xlen == 32 && (op == MEM_LWU || op == MEM_LD || op == MEM_SD)) return 1'b0;
    return 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_mem_lsu_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage_mem_lsu_if : request/grant/response data-memory bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface stage_mem_lsu_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/stage_mem_lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align : byte enables, store-lane replication, load extraction, alignment
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import mem_defs::*;
#(
  parameter int XLEN = 32
) (
  input  mem_op_e                      op,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [XLEN-1:0]              store_data,
  input  logic [XLEN-1:0]              rdata,
  output logic [XLEN/8-1:0]            be,
  output logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              load_val,
  output logic                         misalign
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  mem_size_e       sz;
  logic [OW-1:0]   amask;
  logic [NB-1:0]   base;
  logic [XLEN-1:0] shifted;

  always_comb begin
    sz       = op_size(op);
    amask    = OW'((32'd1 << sz) - 32'd1);
    misalign = |(off & amask);

    case (sz)
      SZ_B:    base = NB'(1);
      SZ_H:    base = NB'(3);
      SZ_W:    base = NB'(15);
      default: base = '1;
    endcase
    be = base << off;

    case (sz)
      SZ_B:    wdata = {NB{store_data[7:0]}};
      SZ_H:    wdata = {(NB/2){store_data[15:0]}};
      SZ_W:    wdata = {(NB/4){store_data[31:0]}};
      default: wdata = store_data;
    endcase

    shifted = rdata >> {off, 3'b000};
    case (sz)
      SZ_B:    load_val = is_signed(op) ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      SZ_H:    load_val = is_signed(op) ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      SZ_W:    load_val = is_signed(op) ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stage_mem_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage_mem_lsu : pipelined MEM stage, issues loads/stores and stalls until response
// Rev 1.0
// ----------------------------------------------------------------------------
module stage_mem_lsu
  import mem_defs::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] reg_waddr_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   reg_wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [XLEN-1:0]   store_data_i,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic              we_o,
  output logic [XLEN-1:0]   reg_wdata_o,
  output logic              valid_o,
  output logic              misalign_o,
  output logic              stall_req_o,
  stage_mem_lsu_if.master   dmem
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  mem_op_e           op_in, op_q, op_sel;
  logic [XLEN-1:0]   addr_q;
  logic [REG_AW-1:0] rd_q;
  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q;
  logic              capture;
  logic              mem_access;

  logic [OW-1:0]     off_sel;
  logic [NB-1:0]     al_be;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_load;
  logic              al_misalign;

  function automatic logic [XLEN-1:0] align_down(logic [XLEN-1:0] a);
    return {a[XLEN-1:OW], {OW{1'b0}}};
  endfunction

  assign op_in      = mem_op_e'(mem_op_i);
  assign mem_access = valid_i && op_legal(op_in, XLEN);
  // Live inputs drive the aligner in IDLE; afterwards the captured op/address do
  assign op_sel     = (state_q == IDLE) ? op_in : op_q;
  assign off_sel    = (state_q == IDLE) ? reg_wdata_i[OW-1:0] : addr_q[OW-1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .op         (op_sel),
    .off        (off_sel),
    .store_data (store_data_i),
    .rdata      (dmem.rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_val   (al_load),
    .misalign   (al_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MEM_NONE;
      addr_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_q    <= op_in;
        addr_q  <= reg_wdata_i;
        rd_q    <= reg_waddr_i;
        we_q    <= we_i;
        be_q    <= al_be;
        wdata_q <= al_wdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    reg_waddr_o = reg_waddr_i;
    we_o        = we_i;
    reg_wdata_o = reg_wdata_i;
    valid_o     = valid_i;
    misalign_o  = 1'b0;
    stall_req_o = 1'b0;
    dmem.req    = 1'b0;
    dmem.we     = 1'b0;
    dmem.addr   = '0;
    dmem.be     = '0;
    dmem.wdata  = '0;

    case (state_q)
      IDLE: begin
        if (mem_access) begin
          if (al_misalign) begin
            valid_o    = 1'b1;
            misalign_o = 1'b1;
            we_o       = 1'b0;
          end else begin
            capture     = 1'b1;
            valid_o     = 1'b0;
            we_o        = 1'b0;
            stall_req_o = 1'b1;
            dmem.req    = 1'b1;
            dmem.we     = is_store(op_in);
            dmem.addr   = align_down(reg_wdata_i);
            dmem.be     = al_be;
            dmem.wdata  = al_wdata;
            state_d     = dmem.gnt ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        reg_waddr_o = rd_q;
        reg_wdata_o = addr_q;
        we_o        = 1'b0;
        valid_o     = 1'b0;
        stall_req_o = 1'b1;
        dmem.req    = 1'b1;
        dmem.we     = is_store(op_q);
        dmem.addr   = align_down(addr_q);
        dmem.be     = be_q;
        dmem.wdata  = wdata_q;
        if (dmem.gnt) state_d = WAIT;
      end
      WAIT: begin
        reg_waddr_o = rd_q;
        reg_wdata_o = addr_q;
        we_o        = 1'b0;
        valid_o     = 1'b0;
        stall_req_o = 1'b1;
        if (dmem.rvalid) begin
          valid_o     = 1'b1;
          stall_req_o = 1'b0;
          if (is_load(op_q)) begin
            we_o        = we_q;
            reg_wdata_o = al_load;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced to zero while reset is held, including the pass-through path
    if (!rst_n) begin
      reg_waddr_o = '0;
      we_o        = 1'b0;
      reg_wdata_o = '0;
      valid_o     = 1'b0;
      misalign_o  = 1'b0;
      stall_req_o = 1'b0;
      dmem.req    = 1'b0;
      dmem.we     = 1'b0;
      dmem.addr   = '0;
      dmem.be     = '0;
      dmem.wdata  = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_lsu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stage_mem_lsu : directed vector bench for the MEM stage (RV32 and RV64 instances)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stage_mem_lsu;
  import mem_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // RV32 instance
  logic        valid_in, we_in;
  logic [4:0]  rd_in;
  logic [31:0] wd_in, sd_in;
  logic [3:0]  op_in;
  logic [4:0]  rd_out;
  logic        we_out, valid_out, mis_out, stall_out;
  logic [31:0] wd_out;
  stage_mem_lsu_if #(.XLEN(32)) bus32 ();

  stage_mem_lsu #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_in), .reg_waddr_i(rd_in), .we_i(we_in),
    .reg_wdata_i(wd_in), .mem_op_i(op_in), .store_data_i(sd_in),
    .reg_waddr_o(rd_out), .we_o(we_out), .reg_wdata_o(wd_out), .valid_o(valid_out),
    .misalign_o(mis_out), .stall_req_o(stall_out), .dmem(bus32)
  );

  // RV64 instance
  logic        v64, we64;
  logic [4:0]  rd64;
  logic [63:0] wd64, sd64;
  logic [3:0]  op64;
  logic [4:0]  rd64_o;
  logic        we64_o, v64_o, mis64_o, st64_o;
  logic [63:0] wd64_o;
  stage_mem_lsu_if #(.XLEN(64)) bus64 ();

  stage_mem_lsu #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .valid_i(v64), .reg_waddr_i(rd64), .we_i(we64),
    .reg_wdata_i(wd64), .mem_op_i(op64), .store_data_i(sd64),
    .reg_waddr_o(rd64_o), .we_o(we64_o), .reg_wdata_o(wd64_o), .valid_o(v64_o),
    .misalign_o(mis64_o), .stall_req_o(st64_o), .dmem(bus64)
  );

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        valid;
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
    logic        e_we;
    logic        e_mis;
  } vec_t;

  vec_t vt[13];

  task automatic run_vec(input vec_t v, input int idx);
    logic mem, ld, st;
    mem = v.valid && (v.op != MEM_NONE) && !v.e_mis;
    ld  = v.op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    st  = v.op inside {MEM_SB, MEM_SH, MEM_SW};
    @(negedge clk);
    valid_in = v.valid; op_in = v.op; wd_in = v.addr; sd_in = v.sdata;
    rd_in = v.rd; we_in = v.we;
    bus32.gnt = 1'b1; bus32.rvalid = 1'b0; bus32.rdata = 32'h0;
    #2;
    if (!mem) begin
      check($sformatf("v%0d_valid", idx), valid_out, v.valid);
      check($sformatf("v%0d_we", idx), we_out, v.e_we);
      check($sformatf("v%0d_wdata", idx), wd_out, v.e_res);
      check($sformatf("v%0d_rd", idx), rd_out, v.rd);
      check($sformatf("v%0d_mis", idx), mis_out, v.e_mis);
      check($sformatf("v%0d_stall", idx), stall_out, 0);
      check($sformatf("v%0d_req", idx), bus32.req, 0);
    end else begin
      check($sformatf("v%0d_req", idx), bus32.req, 1);
      check($sformatf("v%0d_bus_we", idx), bus32.we, st);
      check($sformatf("v%0d_addr", idx), bus32.addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_be", idx), bus32.be, v.e_be);
      check($sformatf("v%0d_bus_wdata", idx), bus32.wdata, v.e_wdata);
      check($sformatf("v%0d_stall_issue", idx), stall_out, 1);
      check($sformatf("v%0d_valid_issue", idx), valid_out, 0);
      @(negedge clk);
      bus32.gnt = 1'b0; bus32.rvalid = 1'b1; bus32.rdata = v.rdata;
      #2;
      check($sformatf("v%0d_valid_done", idx), valid_out, 1);
      check($sformatf("v%0d_stall_done", idx), stall_out, 0);
      check($sformatf("v%0d_req_done", idx), bus32.req, 0);
      check($sformatf("v%0d_we_done", idx), we_out, v.e_we);
      check($sformatf("v%0d_rd_done", idx), rd_out, v.rd);
      if (ld) check($sformatf("v%0d_result", idx), wd_out, v.e_res);
    end
  endtask

  initial begin
    int nstall;
    //          valid op        addr          sdata         rdata         rd  we  be    bus wdata     result        we  mis
    vt[0]  = '{1'b1, MEM_NONE, 32'h0000_1234, 32'h0,        32'h0,        5,  1, 4'h0, 32'h0,        32'h0000_1234, 1, 0};
    vt[1]  = '{1'b1, MEM_LB,   32'h0000_1003, 32'h0,        32'h80FF_FFFF, 7, 1, 4'h8, 32'h0,        32'hFFFF_FF80, 1, 0};
    vt[2]  = '{1'b1, MEM_LBU,  32'h0000_1003, 32'h0,        32'h80FF_FFFF, 7, 1, 4'h8, 32'h0,        32'h0000_0080, 1, 0};
    vt[3]  = '{1'b1, MEM_SH,   32'h0000_2002, 32'hABCD_1234, 32'h0,       3,  1, 4'hC, 32'h1234_1234, 32'h0,        0, 0};
    vt[4]  = '{1'b1, MEM_LW,   32'h0000_1001, 32'h0,        32'h0,        9,  1, 4'h0, 32'h0,        32'h0000_1001, 0, 1};
    vt[5]  = '{1'b1, MEM_LH,   32'h0000_3002, 32'h0,        32'h8001_0000, 10, 1, 4'hC, 32'h0,       32'hFFFF_8001, 1, 0};
    vt[6]  = '{1'b1, MEM_LHU,  32'h0000_3002, 32'h0,        32'h8001_0000, 10, 1, 4'hC, 32'h0,       32'h0000_8001, 1, 0};
    vt[7]  = '{1'b1, MEM_SB,   32'h0000_4001, 32'h0000_0055, 32'h0,       2,  0, 4'h2, 32'h5555_5555, 32'h0,        0, 0};
    vt[8]  = '{1'b1, MEM_SW,   32'h0000_5000, 32'hDEAD_BEEF, 32'h0,       2,  0, 4'hF, 32'hDEAD_BEEF, 32'h0,        0, 0};
    vt[9]  = '{1'b1, MEM_LW,   32'h0000_6004, 32'h0,        32'hCAFE_F00D, 31, 1, 4'hF, 32'h0,       32'hCAFE_F00D, 1, 0};
    vt[10] = '{1'b1, MEM_SH,   32'h0000_2001, 32'h1111_2222, 32'h0,       6,  0, 4'h0, 32'h0,        32'h0000_2001, 0, 1};
    vt[11] = '{1'b0, MEM_LW,   32'h0000_6000, 32'h0,        32'h0,        4,  1, 4'h0, 32'h0,        32'h0000_6000, 1, 0};
    vt[12] = '{1'b1, MEM_LB,   32'h0000_1001, 32'h0,        32'h1234_7F56, 8, 1, 4'h2, 32'h0,        32'h0000_007F, 1, 0};

    // reset state with live, non-zero inputs
    valid_in = 1'b1; op_in = MEM_NONE; wd_in = 32'h1234; sd_in = 32'h0; rd_in = 5'd5; we_in = 1'b1;
    bus32.gnt = 1'b0; bus32.rvalid = 1'b0; bus32.rdata = 32'h0;
    v64 = 1'b1; op64 = MEM_NONE; wd64 = 64'h55; sd64 = 64'h0; rd64 = 5'd1; we64 = 1'b1;
    bus64.gnt = 1'b0; bus64.rvalid = 1'b0; bus64.rdata = 64'h0;
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_we", we_out, 0);
    check("rst_wdata", wd_out, 0);
    check("rst_rd", rd_out, 0);
    check("rst_stall", stall_out, 0);
    check("rst_req", bus32.req, 0);
    check("rst64_wdata", wd64_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // LW with grant delayed 2 cycles and response 3 cycles after grant
    nstall = 0;
    @(negedge clk);
    valid_in = 1'b1; op_in = MEM_LW; wd_in = 32'h0000_7008; rd_in = 5'd12; we_in = 1'b1;
    bus32.gnt = 1'b0; bus32.rvalid = 1'b0;
    #2;
    if (stall_out) nstall++;
    check("dly_req0", bus32.req, 1);
    check("dly_addr0", bus32.addr, 32'h7008);
    @(negedge clk);
    wd_in = 32'hFFFF_FFF1;
    #2;
    if (stall_out) nstall++;
    check("dly_req1", bus32.req, 1);
    check("dly_addr1", bus32.addr, 32'h7008);
    check("dly_be1", bus32.be, 4'hF);
    @(negedge clk);
    bus32.gnt = 1'b1;
    #2;
    if (stall_out) nstall++;
    check("dly_req2", bus32.req, 1);
    check("dly_addr2", bus32.addr, 32'h7008);
    @(negedge clk);
    bus32.gnt = 1'b0;
    #2;
    if (stall_out) nstall++;
    check("dly_req3", bus32.req, 0);
    @(negedge clk);
    bus32.gnt = 1'b1;
    #2;
    if (stall_out) nstall++;
    check("dly_req4", bus32.req, 0);
    check("dly_valid4", valid_out, 0);
    @(negedge clk);
    bus32.gnt = 1'b0; bus32.rvalid = 1'b1; bus32.rdata = 32'h1122_3344;
    #2;
    check("dly_valid", valid_out, 1);
    check("dly_result", wd_out, 32'h1122_3344);
    check("dly_rd", rd_out, 12);
    check("dly_we", we_out, 1);
    check("dly_stall_done", stall_out, 0);
    check("dly_stall_cycles", nstall, 5);

    // reset asserted in WAIT, then a stray response
    @(negedge clk);
    bus32.rvalid = 1'b0;
    valid_in = 1'b1; op_in = MEM_LW; wd_in = 32'h0000_0100; rd_in = 5'd3; we_in = 1'b1;
    bus32.gnt = 1'b1;
    @(negedge clk);
    bus32.gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mrst_stall", stall_out, 0);
    check("mrst_req", bus32.req, 0);
    check("mrst_valid", valid_out, 0);
    check("mrst_wdata", wd_out, 0);
    check("mrst_rd", rd_out, 0);
    check("mrst_addr", bus32.addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 1'b0; we_in = 1'b0; bus32.rvalid = 1'b1; bus32.rdata = 32'hFFFF_FFFF;
    #2;
    check("stray_valid", valid_out, 0);
    check("stray_stall", stall_out, 0);
    @(negedge clk);
    bus32.rvalid = 1'b0;
    valid_in = 1'b1; op_in = MEM_LW; wd_in = 32'h0000_0200; rd_in = 5'd3; we_in = 1'b1;
    #2;
    check("post_rst_idle_req", bus32.req, 1);
    check("post_rst_addr", bus32.addr, 32'h200);
    bus32.gnt = 1'b1;
    @(negedge clk);
    bus32.gnt = 1'b0; bus32.rvalid = 1'b1; bus32.rdata = 32'h0000_00AB;
    #2;
    check("post_rst_result", wd_out, 32'hAB);
    @(negedge clk);
    bus32.rvalid = 1'b0; valid_in = 1'b0;

    // RV64: SD at 0x8
    v64 = 1'b1; op64 = MEM_SD; wd64 = 64'h8; sd64 = 64'h0123_4567_89AB_CDEF; rd64 = 5'd2; we64 = 1'b0;
    bus64.gnt = 1'b1;
    #2;
    check("sd64_be", bus64.be, 8'hFF);
    check("sd64_addr", bus64.addr, 64'h8);
    check("sd64_wdata", bus64.wdata, 64'h0123_4567_89AB_CDEF);
    check("sd64_we", bus64.we, 1);
    @(negedge clk);
    bus64.gnt = 1'b0; bus64.rvalid = 1'b1;
    #2;
    check("sd64_valid", v64_o, 1);
    check("sd64_we_o", we64_o, 0);
    // RV64: LWU at 0x14
    @(negedge clk);
    bus64.rvalid = 1'b0;
    op64 = MEM_LWU; wd64 = 64'h14; rd64 = 5'd9; we64 = 1'b1; bus64.gnt = 1'b1;
    #2;
    check("lwu64_be", bus64.be, 8'hF0);
    check("lwu64_addr", bus64.addr, 64'h10);
    @(negedge clk);
    bus64.gnt = 1'b0; bus64.rvalid = 1'b1; bus64.rdata = 64'h8000_0000_0000_0000;
    #2;
    check("lwu64_result", wd64_o, 64'h0000_0000_8000_0000);
    // RV64: LD at 0xC is misaligned
    @(negedge clk);
    bus64.rvalid = 1'b0;
    op64 = MEM_LD; wd64 = 64'hC; bus64.gnt = 1'b0;
    #2;
    check("ld64_mis", mis64_o, 1);
    check("ld64_req", bus64.req, 0);
    check("ld64_stall", st64_o, 0);
    @(negedge clk);
    v64 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_mem_lsu.md
# stage_mem_lsu

Parametrised memory stage for the pipelined RISC-V core, sitting between the EX/MEM and MEM/WB pipeline registers. Non-memory instructions pass through combinationally with no added latency. Loads and stores are issued on a request/grant/response data-memory bus, and the pipeline is stalled until the response arrives. The stage generates byte enables and store-lane replication, extracts and sign/zero-extends load data, and flags misaligned accesses.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64; 64 enables LWU/LD/SD.
- REG_AW, 5: register address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX/MEM holds a valid instruction.
- reg_waddr_i  in  REG_AW  destination register.
- we_i  in  1  register write enable from EX.
- reg_wdata_i  in  XLEN  ALU result; effective address for memory ops.
- mem_op_i  in  4  MEM_NONE, LB, LH, LW, LBU, LHU, LWU, LD, SB, SH, SW, SD (package encoding).
- store_data_i  in  XLEN  rs2 value for stores.
- reg_waddr_o / we_o / reg_wdata_o  out  REG_AW / 1 / XLEN  to MEM/WB.
- valid_o  out  1  output instruction valid this cycle.
- misalign_o  out  1  access address not naturally aligned; no bus access is made.
- stall_req_o  out  1  to pipeline control; freezes PC, IF/ID, ID/EX and EX/MEM.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  bus write.
- dmem_addr_o  out  XLEN  bus address, aligned down to XLEN/8 bytes.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response; acknowledges writes, carries read data.
- dmem_rdata_i  in  XLEN  full-word read data.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, no memory op, or valid_i=0:
  - All `*_o` follow their inputs combinationally.
  - stall_req_o=0.
  - dmem_req_o=0.
- IDLE, valid memory op, aligned:
  - Capture address, op, rd, we and the byte-enable/wdata image into registers.
  - Drive dmem_req_o=1 from the live inputs.
  - stall_req_o=1, valid_o=0.
  - Next state WAIT if dmem_gnt_i, else REQ.
- REQ:
  - Hold req, addr, be, wdata and we from the captured registers; they do not change until grant.
  - stall_req_o=1.
  - On dmem_gnt_i go to WAIT.
- WAIT:
  - dmem_req_o=0.
  - stall_req_o=1 until dmem_rvalid_i.
  - On dmem_rvalid_i:
    - valid_o=1 and stall_req_o=0, combinationally.
    - Load: we_o=captured we, reg_wdata_o=extracted value.
    - Store: we_o=0.
    - Next state IDLE.
- Misaligned access (LH/SH with addr[0]; LW/LWU/SW with addr[1:0]≠0; LD/SD with addr[2:0]≠0):
  - No request, no stall.
  - valid_o=1, misalign_o=1, we_o=0.
- Byte enables, where off = addr mod XLEN/8:
  - Byte: 1<<off.
  - Half: 2'b11<<off.
  - Word: 4'hF<<off.
  - Double: all ones.
- Store data: the byte, half or word is replicated across all lanes.
- Load data: rdata >> (8·off), then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to XLEN.
- Ignored inputs: dmem_gnt_i outside request cycles, and dmem_rvalid_i outside WAIT.

## Timing
- Non-memory ops: 0 cycles of added latency.
- Memory op, zero-wait bus (gnt with req, rvalid next cycle):
  - Result on cycle N+1.
  - Exactly one stall cycle.
- Each cycle of grant delay or response delay adds one stall cycle.
- At most one transaction is outstanding.
- Reset (rst_n low, asynchronous):
  - State IDLE, all capture registers 0.
  - Every output is 0: stall_req_o, dmem_req_o, valid_o, we_o, misalign_o, and all data/address outputs.
- Reset mid-transaction: the transaction is abandoned; a late rvalid after reset is ignored in IDLE.

## Structure
- Shared package `mem_defs`: the mem_op encoding, MEM_NONE, the XLEN default, and the op-class helpers (is_load, is_store, size, signed).
- Sub-module `lsu_align` (purely combinational):
  - Inputs: op, addr offset, store data, read data.
  - Outputs: be, replicated wdata, extended load value, misaligned flag.
  - Instantiated once; the FSM and capture registers stay in stage_mem_lsu.

## Test plan
- ALU op, rd=5, wdata=0x1234, we=1 -> same values on outputs in the same cycle, stall_req_o=0, dmem_req_o=0.
- LB at 0x1003, rdata=0x80FFFFFF, zero-wait bus -> be=4'b1000, one stall cycle, reg_wdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x2002, store_data=0xABCD1234 -> be=4'b1100, wdata=0x12341234, we_o=0 on completion.
- LW with gnt delayed 2 cycles and rvalid 3 cycles after grant -> req held stable with the same addr, stall_req_o high for 5 cycles, then the result.
- LW at 0x1001 -> misalign_o=1, no request, no stall, we_o=0.
- rst_n asserted in WAIT, then a stray rvalid -> all outputs 0, stays IDLE, no valid_o; XLEN=64 SD at 0x8 -> be=8'hFF.
